// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int BURST_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Grants the write port of a FIFO to one of two requesters in bounded bursts,
// alternating on contention and stalling cleanly while the FIFO is full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] din0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din1,
  input  logic              fifo_full,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din
);

  localparam logic [3:0] CNT_MAX = 4'(BURST_MAX);

  state_t     r_state;
  logic [3:0] r_burst_cnt;
  logic       r_last_srv;   // 1 = requester 1 was served last

  state_t     w_next_state;
  logic [3:0] w_next_cnt;
  logic       w_next_last;
  logic       w_own_req;
  logic       w_other_req;
  logic       w_own_ack;
  logic       w_release;

  assign gnt0       = (r_state == OWN0);
  assign gnt1       = (r_state == OWN1);
  assign ack0       = gnt0 & req0 & ~fifo_full;
  assign ack1       = gnt1 & req1 & ~fifo_full;
  assign fifo_wr_en = ack0 | ack1;
  assign fifo_din   = gnt0 ? din0 : (gnt1 ? din1 : '0);

  assign w_own_req   = gnt0 ? req0 : req1;
  assign w_other_req = gnt0 ? req1 : req0;
  assign w_own_ack   = ack0 | ack1;
  assign w_release   = ~w_own_req | (w_own_ack & ((r_burst_cnt + 4'd1) == CNT_MAX));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_burst_cnt;
    w_next_last  = r_last_srv;
    case (r_state)
      IDLE: begin
        w_next_cnt = '0;
        if (req0 && (!req1 || r_last_srv)) w_next_state = OWN0;
        else if (req1)                     w_next_state = OWN1;
      end
      OWN0, OWN1: begin
        if (w_release) begin
          // Hand over directly to a waiting peer; otherwise re-grant or go idle.
          w_next_last = (r_state == OWN1);
          w_next_cnt  = '0;
          if (w_other_req)    w_next_state = (r_state == OWN0) ? OWN1 : OWN0;
          else if (!w_own_req) w_next_state = IDLE;
        end else if (w_own_ack) begin
          w_next_cnt = r_burst_cnt + 4'd1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_last_srv  <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_burst_cnt <= w_next_cnt;
      r_last_srv  <= w_next_last;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic on
// two instances (burst 4 and burst 1) checked against a behavioural model.
module tb_fifo_wr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0;
  logic       req1;
  logic       fifo_full;
  logic [7:0] din0;
  logic [7:0] din1;

  logic       gnt0_a, gnt1_a, ack0_a, ack1_a, wr_en_a;
  logic [7:0] fdin_a;
  logic       gnt0_b, gnt1_b, ack0_b, ack1_b, wr_en_b;
  logic [7:0] fdin_b;

  int tests = 0;
  int fails = 0;

  fifo_wr_arbiter #(.BURST_MAX(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1), .fifo_full(fifo_full),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .ack0(ack0_a), .ack1(ack1_a),
    .fifo_wr_en(wr_en_a), .fifo_din(fdin_a)
  );

  fifo_wr_arbiter #(.BURST_MAX(1), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1), .fifo_full(fifo_full),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b),
    .fifo_wr_en(wr_en_b), .fifo_din(fdin_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grants must be mutually exclusive on both instances at all times.
  always @(negedge clk) begin
    assert (!(gnt0_a && gnt1_a) && !(gnt0_b && gnt1_b))
    else begin
      $display("FAIL gnt_exclusive t=%0t a=%b%b b=%b%b required no double grant",
               $time, gnt0_a, gnt1_a, gnt0_b, gnt1_b);
      fails++;
    end
  end

  task automatic drive(input logic r0, input logic [7:0] d0,
                       input logic r1, input logic [7:0] d1, input logic full);
    req0 = r0; din0 = d0; req1 = r1; din1 = d1; fifo_full = full;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1, 8'h5A, 1, 8'hA5, 0);
    #3 rst_n = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({gnt0_a, gnt1_a, ack0_a, ack1_a, wr_en_a, fdin_a} !== 13'd0) begin
      $display("FAIL reset_outputs_a got=%h required=0",
               {gnt0_a, gnt1_a, ack0_a, ack1_a, wr_en_a, fdin_a});
      fails++;
    end
    @(negedge clk); #1;
    tests++;
    if ({gnt0_b, gnt1_b, ack0_b, ack1_b, wr_en_b, fdin_b} !== 13'd0) begin
      $display("FAIL reset_outputs_b got=%h required=0",
               {gnt0_b, gnt1_b, ack0_b, ack1_b, wr_en_b, fdin_b});
      fails++;
    end
    // Release with both requesting: requester 0 must win the first tie.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({gnt0_a, gnt1_a} !== 2'b00) begin
      $display("FAIL reset_release_idle got=%b%b required=00", gnt0_a, gnt1_a);
      fails++;
    end
    @(negedge clk); #1;
    tests++;
    if ({gnt0_a, gnt1_a, fdin_a} !== {2'b10, 8'h5A}) begin
      $display("FAIL reset_first_tie got gnt=%b%b din=%h required gnt=10 din=5a",
               gnt0_a, gnt1_a, fdin_a);
      fails++;
    end
  endtask

  task automatic test_single_requester();
    apply_reset();
    drive(1, 8'h11, 0, 8'h00, 0);
    #1;
    tests++;
    if ({gnt0_a, ack0_a} !== 2'b00) begin
      $display("FAIL single_latency got gnt0=%b ack0=%b required 0 0", gnt0_a, ack0_a);
      fails++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din0 = 8'(8'h11 + i);
      #1;
      tests++;
      if ({gnt0_a, ack0_a, wr_en_a, fdin_a} !== {3'b111, 8'(8'h11 + i)}) begin
        $display("FAIL single_word%0d got gnt/ack/wr=%b%b%b din=%h required 111 din=%h",
                 i, gnt0_a, ack0_a, wr_en_a, fdin_a, 8'(8'h11 + i));
        fails++;
      end
    end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    tests++;
    if ({ack0_a, wr_en_a} !== 2'b00) begin
      $display("FAIL single_drop_ack got ack0=%b wr=%b required 0 0", ack0_a, wr_en_a);
      fails++;
    end
    @(negedge clk); #1;
    tests++;
    if ({gnt0_a, gnt1_a} !== 2'b00) begin
      $display("FAIL single_idle got gnt=%b%b required 00", gnt0_a, gnt1_a);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    apply_reset();
    for (int c = 0; c < 17; c++) begin
      if (c > 0) @(negedge clk);
      drive(1, 8'(8'hA0 + c), 1, 8'(8'hB0 + c), 0);
      #1;
      exp_a = (c == 0) ? 2'b00 : ((((c - 1) / 4) % 2) == 0 ? 2'b10 : 2'b01);
      exp_b = (c == 0) ? 2'b00 : ((((c - 1) % 2) == 0) ? 2'b10 : 2'b01);
      tests++;
      if ({gnt0_a, gnt1_a, ack0_a, ack1_a} !== {exp_a, exp_a} ||
          fdin_a !== (exp_a == 2'b10 ? din0 : (exp_a == 2'b01 ? din1 : 8'h00))) begin
        $display("FAIL b2b_a c=%0d got gnt=%b%b ack=%b%b din=%h required gnt=%b",
                 c, gnt0_a, gnt1_a, ack0_a, ack1_a, fdin_a, exp_a);
        fails++;
      end
      tests++;
      if ({gnt0_b, gnt1_b, ack0_b, ack1_b} !== {exp_b, exp_b} ||
          fdin_b !== (exp_b == 2'b10 ? din0 : (exp_b == 2'b01 ? din1 : 8'h00))) begin
        $display("FAIL b2b_b c=%0d got gnt=%b%b ack=%b%b din=%h required gnt=%b",
                 c, gnt0_b, gnt1_b, ack0_b, ack1_b, fdin_b, exp_b);
        fails++;
      end
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    drive(0, 8'h00, 1, 8'h21, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      din1 = 8'(8'h21 + i);
      #1;
      tests++;
      if ({ack1_a, fdin_a} !== {1'b1, 8'(8'h21 + i)}) begin
        $display("FAIL stall_pre%0d got ack1=%b din=%h required 1 %h",
                 i, ack1_a, fdin_a, 8'(8'h21 + i));
        fails++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 8'h99, 1, 8'h23, 1);
      #1;
      tests++;
      if ({gnt1_a, ack1_a, ack0_a, wr_en_a} !== 4'b1000) begin
        $display("FAIL stall_full%0d got gnt1/ack1/ack0/wr=%b%b%b%b required 1000",
                 i, gnt1_a, ack1_a, ack0_a, wr_en_a);
        fails++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      fifo_full = 1'b0;
      din1 = 8'(8'h23 + i);
      #1;
      tests++;
      if ({ack1_a, wr_en_a, fdin_a} !== {2'b11, 8'(8'h23 + i)}) begin
        $display("FAIL stall_post%0d got ack1=%b wr=%b din=%h required 1 1 %h",
                 i, ack1_a, wr_en_a, fdin_a, 8'(8'h23 + i));
        fails++;
      end
    end
    @(negedge clk); #1;
    tests++;
    if ({gnt0_a, gnt1_a} !== 2'b10) begin
      $display("FAIL stall_release got gnt=%b%b required 10", gnt0_a, gnt1_a);
      fails++;
    end
  endtask

  task automatic test_req_drop();
    apply_reset();
    drive(1, 8'h31, 0, 8'h00, 0);
    @(negedge clk); #1;
    tests++;
    if ({gnt0_a, ack0_a, fdin_a} !== {2'b11, 8'h31}) begin
      $display("FAIL drop_ack got gnt0=%b ack0=%b din=%h required 1 1 31",
               gnt0_a, ack0_a, fdin_a);
      fails++;
    end
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({gnt0_a, gnt1_a} !== 2'b00) begin
      $display("FAIL drop_idle got gnt=%b%b required 00", gnt0_a, gnt1_a);
      fails++;
    end
    drive(0, 8'h00, 1, 8'h41, 0);
    @(negedge clk); #1;
    tests++;
    if ({gnt1_a, ack1_a, fdin_a} !== {2'b11, 8'h41}) begin
      $display("FAIL drop_regrant got gnt1=%b ack1=%b din=%h required 1 1 41",
               gnt1_a, ack1_a, fdin_a);
      fails++;
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    drive(0, 8'h00, 1, 8'h51, 0);
    @(negedge clk); #1;
    tests++;
    if (ack1_a !== 1'b1) begin
      $display("FAIL midrst_own1 got ack1=%b required 1", ack1_a);
      fails++;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({gnt0_a, gnt1_a, ack0_a, ack1_a, wr_en_a, fdin_a} !== 13'd0) begin
      $display("FAIL midrst_outputs got=%h required=0",
               {gnt0_a, gnt1_a, ack0_a, ack1_a, wr_en_a, fdin_a});
      fails++;
    end
    drive(1, 8'h61, 1, 8'h71, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    tests++;
    if ({gnt0_a, gnt1_a, fdin_a} !== {2'b10, 8'h61}) begin
      $display("FAIL midrst_tie got gnt=%b%b din=%h required 10 61",
               gnt0_a, gnt1_a, fdin_a);
      fails++;
    end
  endtask

  task automatic test_random();
    int         owner [2];   // -1 idle, else index of the granted requester
    int         words [2];   // words accepted in the current grant
    int         last  [2];
    int         bmax  [2];
    logic       r [2];
    logic [7:0] d [2];
    logic       full;
    logic [12:0] got;
    logic [12:0] exp;
    logic       ack;
    int         x;
    bmax[0] = 4;
    bmax[1] = 1;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; words[k] = 0; last[k] = 1;
    end
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      r[0] = ($urandom_range(0, 3) != 0);
      r[1] = ($urandom_range(0, 3) != 0);
      d[0] = 8'($urandom);
      d[1] = 8'($urandom);
      full = ($urandom_range(0, 4) == 0);
      drive(r[0], d[0], r[1], d[1], full);
      #1;
      for (int k = 0; k < 2; k++) begin
        ack = (owner[k] >= 0) && r[owner[k]] && !full;
        exp = {owner[k] == 0, owner[k] == 1,
               ack && owner[k] == 0, ack && owner[k] == 1, ack,
               (owner[k] >= 0) ? d[owner[k]] : 8'h00};
        got = (k == 0) ? {gnt0_a, gnt1_a, ack0_a, ack1_a, wr_en_a, fdin_a}
                       : {gnt0_b, gnt1_b, ack0_b, ack1_b, wr_en_b, fdin_b};
        tests++;
        if (got !== exp) begin
          $display("FAIL random_k%0d c=%0d got=%h required=%h", k, c, got, exp);
          fails++;
        end
        if (owner[k] < 0) begin
          if (r[0] && r[1]) owner[k] = (last[k] == 1) ? 0 : 1;
          else if (r[0])    owner[k] = 0;
          else if (r[1])    owner[k] = 1;
          words[k] = 0;
        end else begin
          x = owner[k];
          if (ack) words[k] = words[k] + 1;
          if (!r[x] || (ack && words[k] == bmax[k])) begin
            last[k]  = x;
            words[k] = 0;
            if (r[1 - x])  owner[k] = 1 - x;
            else if (r[x]) owner[k] = x;
            else           owner[k] = -1;
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0);
    test_reset();
    test_single_requester();
    test_back_to_back();
    test_full_stall();
    test_req_drop();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: BURST_MAX, 4, max words one requester may write per grant (legal 1..15).
REQ-002 Parameter: DATA_W, 8, data width (matches the async FIFO din).
REQ-003 clk  in  1  single block clock, also the FIFO write clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0  in  1  requester 0 has a word on din0.
REQ-006 din0  in  DATA_W  requester 0 write data.
REQ-007 req1  in  1  requester 1 has a word on din1.
REQ-008 din1  in  DATA_W  requester 1 write data.
REQ-009 fifo_full  in  1  FIFO full flag, synchronous to clk.
REQ-010 gnt0  out  1  requester 0 owns the write port (registered).
REQ-011 gnt1  out  1  requester 1 owns the write port (registered).
REQ-012 ack0  out  1  din0 accepted this cycle (combinational).
REQ-013 ack1  out  1  din1 accepted this cycle (combinational).
REQ-014 fifo_wr_en  out  1  FIFO write strobe (combinational).
REQ-015 fifo_din  out  DATA_W  FIFO write data (combinational mux).

Function
REQ-016 FSM states SHALL be IDLE, OWN0 and OWN1; gnt0 = (state==OWN0) and gnt1 = (state==OWN1), never both high.
REQ-017 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the requester not recorded in last_srv; neither -> stay in IDLE.
REQ-018 Grant latency: request seen in IDLE at edge N -> gnt high after edge N; first accept possible in cycle N+1.
REQ-019 ackx = gntx & reqx & !fifo_full; fifo_wr_en = ack0 | ack1; fifo_din = din of the current owner, 0 in IDLE.
REQ-020 burst_cnt (4 bits) SHALL clear on every grant entry and increment on each ack; it holds while fifo_full stalls.
REQ-021 Release in OWNx SHALL occur at the edge where reqx is low, or where an ack makes burst_cnt reach BURST_MAX.
REQ-022 On release: other requester pending -> OWN(other) directly (no IDLE bubble); else reqx still high -> OWNx with burst_cnt cleared; else -> IDLE.
REQ-023 last_srv SHALL update to x on every release from OWNx.
REQ-024 fifo_full high: no ack and no write; grant, burst_cnt and state are held; no timeout.
REQ-025 fifo_full falling: ack resumes in the same cycle fifo_full is low; no word is lost or duplicated.
REQ-026 Requester dropping reqx mid-burst SHALL end the grant; words already accepted stand.

Reset
REQ-027 rst_n low SHALL force state=IDLE, burst_cnt=0 and last_srv=1 (requester 0 wins the first tie), asynchronously.
REQ-028 During reset gnt0/gnt1/ack0/ack1/fifo_wr_en SHALL be 0 and fifo_din 0; a burst cut by reset is abandoned.
REQ-029 Reset deassertion SHALL take effect at the next clk edge; first grant possible one edge later.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enum (IDLE/OWN0/OWN1), DATA_W default and BURST_MAX default.
REQ-031 Single module, no sub-module; one sequential process (state, burst_cnt, last_srv) plus combinational ack/mux logic.
REQ-032 The block SHALL instantiate nothing; the FIFO is connected at the parent level.

Verification
REQ-033 Reset, then req0=1 alone with din0=0x11..0x16, fifo_full=0 -> gnt0 one cycle later; 4 acks (0x11-0x14), then re-grant to 0 and acks for 0x15, 0x16.
REQ-034 req0=req1=1 held, fifo_full=0 -> bursts alternate 0,1,0,1 at 4 words each; no idle cycle between grants; first burst to 0.
REQ-035 In OWN1 after 2 acks, fifo_full=1 for 5 cycles -> no fifo_wr_en, gnt1 held, burst_cnt=2; then 2 more acks and release.
REQ-036 In OWN0 after 1 ack, req0 drops with req1=0 -> IDLE next edge; then req1=1 -> OWN1.
REQ-037 rst_n pulsed low mid-burst in OWN1 -> outputs 0 immediately; after release with both requesting -> OWN0 granted first.
REQ-038 BURST_MAX=1, both requesting -> grant alternates every accepted word; gnt0&gnt1 never both 1 (assertion).
